hilo_muldiv: RTL and testbench
==============================

# hilo_muldiv

Iterative multiply/divide unit that produces the HI/LO pair consumed by the register file's `hi_reg`/`lo_reg` inputs. The execute stage issues MULT/MULTU/DIV/DIVU, and MTHI/MTLO writes, to this block. It holds HI/LO as architectural state and presents them continuously on `hi_reg`/`lo_reg`. `busy` stalls the pipeline on MFHI/MFLO until the result is written.

## Interface
Parameters:
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.

Ports:
- `clk`  in  1: pipeline clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: issue the operation selected by `op`.
- `op`  in  2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs_val`  in  32: multiplicand or dividend.
- `rt_val`  in  32: multiplier or divisor.
- `mthi`  in  1: write `rs_val` into HI.
- `mtlo`  in  1: write `rs_val` into LO.
- `hi_reg`  out  32: current HI.
- `lo_reg`  out  32: current LO.
- `busy`  out  1: an operation is in flight.
- `done`  out  1: one-cycle pulse; HI/LO were updated this edge.
- `div_zero`  out  1: sticky; the last DIV/DIVU had `rt_val`=0. Cleared by the next `start`.

## Operation
- Reset (any time, including mid-operation): HI=0, LO=0, `busy`=0, `done`=0, `div_zero`=0, state IDLE, counter=0. An in-flight operation is discarded.
- States:
  - IDLE -> RUN when `start`.
  - RUN -> FIX after 32 iterations.
  - FIX -> IDLE unconditionally.
- IDLE:
  - `start` latches `op`, the operand magnitudes and the result sign.
  - Sign handling: for signed ops each operand is replaced by its magnitude (two's-complement negate if bit 31 is set). Result sign: product or quotient sign = `rs_val[31]` XOR `rt_val[31]`; remainder sign = `rs_val[31]`. Unsigned ops use a positive sign.
  - MTHI/MTLO are applied on the same edge. If `start` coincides with `mthi`/`mtlo`, both take effect; the operation result overwrites HI/LO at FIX.
- RUN, multiply:
  - 64-bit shift-add. Accumulator {P_hi, P_lo} starts as {0, multiplier}.
  - Each iteration: if P_lo[0], P_hi += multiplicand, keeping the 33-bit carry. Then shift the 65-bit {carry, P_hi, P_lo} right by 1.
- RUN, divide:
  - Restoring division. Remainder R (33 bits) = 0; quotient register Q = dividend.
  - Each iteration: shift {R, Q} left by 1, then trial = R − divisor. If trial ≥ 0: R = trial and Q[0] = 1; otherwise Q[0] = 0.
- FIX:
  - Multiply: apply the sign; if negative, {HI, LO} = 64-bit two's-complement negation of the product. Otherwise HI = upper 32 bits, LO = lower 32 bits.
  - Divide: LO = quotient, HI = remainder, each negated per its sign.
  - Divisor zero (checked at `start`): LO = 0xFFFFFFFF, HI = `rs_val` as latched, with no sign fixup; `div_zero` is set.
  - Overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0. This is the natural wrap; no flag is raised.
- While `busy`: `start`, `mthi` and `mtlo` are ignored. HI/LO hold their old values until FIX.

## Timing
- `start` sampled at edge N:
  - `busy` = 1 after edge N.
  - RUN covers edges N+1..N+32.
  - At edge N+33 (FIX), HI/LO are written, `done` = 1 for the cycle after N+33, and `busy` = 0 after N+33.
  - Total latency: 33 cycles, fixed for all ops and operand values, including division by zero.
- A new `start` is accepted at edge N+34, the first IDLE cycle. Back-to-back ops therefore issue 34 cycles apart.
- MTHI/MTLO have 1-cycle latency: `hi_reg`/`lo_reg` reflect the value after the sampling edge.
- `hi_reg`/`lo_reg` are registered outputs; no combinational path from the inputs.
- `done` is never high while `busy` is high.

## Test plan
- Reset, then MULTU 0xFFFFFFFF × 0xFFFFFFFF:
  - `busy` is high for exactly 33 cycles.
  - `done` pulses once.
  - HI = 0xFFFFFFFE, LO = 0x00000001.
- MULT −3 × 5 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
- MULT 0x80000000 × 0x80000000 -> HI = 0x40000000, LO = 0.
- DIV −7 / 2:
  - LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - Then DIVU 7 / 0 -> LO = 0xFFFFFFFF, HI = 7, `div_zero` = 1.
  - A following `start` clears `div_zero`.
- DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0, `div_zero` = 0.
- Busy-time input handling:
  - MTHI 0x1234 while idle -> HI = 0x1234 next cycle.
  - Start MULTU 2 × 3, then assert `start` and `mthi` at cycle 10 -> both ignored; HI = 0, LO = 6 at completion.
  - Repeat, and pull `rst_n` low at cycle 20 -> HI/LO/`busy`/`done` are 0 immediately.
  - After release, a new MULTU 4 × 4 completes in 33 cycles with LO = 16.

Source files
------------

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative 32-cycle multiply/divide unit that owns the HI/LO pair.
module hilo_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi_reg,
  output logic [WIDTH-1:0] lo_reg,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned PW    = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   rs_raw_q, rs_raw_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH:0]     acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  // Operand magnitudes and one-iteration step results for both algorithms
  logic               rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [WIDTH:0]     mul_add, mul_sum;
  logic [WIDTH:0]     div_sh, div_trial, div_dvs;
  logic               div_ge;
  logic [PW-1:0]      prod, prod_neg;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Sign extraction, shift-add and restore-divide datapath
  always_comb begin
    rs_neg    = ~op[0] & rs_val[WIDTH-1];
    rt_neg    = ~op[0] & rt_val[WIDTH-1];
    rs_mag    = rs_neg ? (~rs_val + WIDTH'(1)) : rs_val;
    rt_mag    = rt_neg ? (~rt_val + WIDTH'(1)) : rt_val;
    mul_add   = acc_lo_q[0] ? {1'b0, mcand_q} : '0;
    mul_sum   = acc_hi_q + mul_add;
    div_sh    = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
    div_dvs   = {1'b0, mcand_q};
    div_trial = div_sh - div_dvs;
    div_ge    = (div_sh >= div_dvs);
    prod      = {acc_hi_q[WIDTH-1:0], acc_lo_q};
    prod_neg  = ~prod + PW'(1);
    quo_fix   = neg_res_q ? (~acc_lo_q + WIDTH'(1)) : acc_lo_q;
    rem_fix   = neg_rem_q ? (~acc_hi_q[WIDTH-1:0] + WIDTH'(1)) : acc_hi_q[WIDTH-1:0];
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    rs_raw_d   = rs_raw_q;
    mcand_d    = mcand_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    case (state_q)
      S_IDLE: begin
        if (mthi) hi_d = rs_val;
        if (mtlo) lo_d = rs_val;
        if (start) begin
          state_d    = S_RUN;
          busy_d     = 1'b1;
          div_zero_d = 1'b0;
          cnt_d      = '0;
          is_div_d   = op[1];
          neg_res_d  = rs_neg ^ rt_neg;
          neg_rem_d  = rs_neg;
          dz_d       = op[1] & (rt_val == '0);
          rs_raw_d   = rs_val;
          acc_hi_d   = '0;
          mcand_d    = op[1] ? rt_mag : rs_mag;
          acc_lo_d   = op[1] ? rs_mag : rt_mag;
        end
      end
      S_RUN: begin
        if (is_div_q) begin
          acc_hi_d = div_ge ? div_trial : div_sh;
          acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
        end else begin
          acc_hi_d = {1'b0, mul_sum[WIDTH:1]};
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = S_FIX;
          cnt_d   = '0;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (!is_div_q) begin
          {hi_d, lo_d} = neg_res_q ? prod_neg : prod;
        end else if (dz_q) begin
          hi_d       = rs_raw_q;
          lo_d       = '1;
          div_zero_d = 1'b1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      rs_raw_q   <= '0;
      mcand_q    <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      rs_raw_q   <= rs_raw_d;
      mcand_q    <= mcand_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign hi_reg   = hi_q;
  assign lo_reg   = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: directed vector table plus hand-written busy/reset sequences.
module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        mthi, mtlo;
  logic [31:0] hi_reg, lo_reg;
  logic        busy, done, div_zero;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dz;
  } vec_t;

  vec_t vecs[10];

  hilo_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .mthi(mthi), .mtlo(mtlo),
    .hi_reg(hi_reg), .lo_reg(lo_reg), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op at a negedge and observe 40 cycles of busy/done behaviour
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic mh, input logic ml,
                       output int bc, output int dc, output int both, output logic dz_first);
    start = 1'b1; op = o; rs_val = a; rt_val = b; mthi = mh; mtlo = ml;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    dz_first = div_zero;
    bc = 0; dc = 0; both = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) bc++;
      if (done) dc++;
      if (busy && done) both++;
      @(negedge clk);
    end
  endtask

  initial begin
    int   bc, dc, both;
    logic dzf;

    vecs[0] = '{"multu_max",  OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1] = '{"mult_m3x5",  OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[2] = '{"mult_min2",  OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[3] = '{"div_m7d2",   OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4] = '{"divu_7d0",   OP_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1};
    vecs[5] = '{"div_ovf",    OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[6] = '{"divu_100d7", OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[7] = '{"div_7dm2",   OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[8] = '{"div_m8d0",   OP_DIV,   32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
    vecs[9] = '{"multu_shift",OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};

    rst_n = 1'b0; start = 1'b0; op = '0; rs_val = '0; rt_val = '0; mthi = 1'b0; mtlo = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_hi", hi_reg, 32'h0);
    chk("reset_lo", lo_reg, 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_dz", 32'(div_zero), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven ops; each start also must clear div_zero left by the prior op
    for (int v = 0; v < 10; v++) begin
      do_op(vecs[v].op, vecs[v].rs, vecs[v].rt, 1'b0, 1'b0, bc, dc, both, dzf);
      chk({vecs[v].name, "_busy_cycles"}, 32'(bc), 32'd33);
      chk({vecs[v].name, "_done_pulses"}, 32'(dc), 32'd1);
      chk({vecs[v].name, "_done_while_busy"}, 32'(both), 32'd0);
      chk({vecs[v].name, "_dz_cleared_by_start"}, 32'(dzf), 32'h0);
      chk({vecs[v].name, "_hi"}, hi_reg, vecs[v].exp_hi);
      chk({vecs[v].name, "_lo"}, lo_reg, vecs[v].exp_lo);
      chk({vecs[v].name, "_dz"}, 32'(div_zero), 32'(vecs[v].exp_dz));
    end

    // MTHI / MTLO while idle, one-cycle latency
    mthi = 1'b1; rs_val = 32'h00001234;
    @(negedge clk);
    mthi = 1'b0;
    chk("mthi_idle", hi_reg, 32'h00001234);
    mtlo = 1'b1; rs_val = 32'h00005678;
    @(negedge clk);
    mtlo = 1'b0;
    chk("mtlo_idle", lo_reg, 32'h00005678);
    chk("mtlo_keeps_hi", hi_reg, 32'h00001234);

    // start + mthi at cycle 10 of a running MULTU 2x3 are ignored
    start = 1'b1; op = OP_MULTU; rs_val = 32'd2; rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0;
    bc = 0; dc = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) bc++;
      if (done) dc++;
      if (i == 9) begin
        start = 1'b1; mthi = 1'b1; op = OP_DIV; rs_val = 32'h0000DEAD; rt_val = 32'h0;
      end else begin
        start = 1'b0; mthi = 1'b0;
      end
      if (i == 10) begin
        chk("busy_hi_holds", hi_reg, 32'h00001234);
        chk("busy_lo_holds", lo_reg, 32'h00005678);
      end
      @(negedge clk);
    end
    chk("ignore_busy_cycles", 32'(bc), 32'd33);
    chk("ignore_done_pulses", 32'(dc), 32'd1);
    chk("ignore_hi", hi_reg, 32'h0);
    chk("ignore_lo", lo_reg, 32'd6);
    chk("ignore_dz", 32'(div_zero), 32'h0);

    // start and mthi on the same idle edge: MTHI visible, then result overwrites
    do_op(OP_MULTU, 32'd5, 32'd7, 1'b1, 1'b0, bc, dc, both, dzf);
    chk("same_edge_hi", hi_reg, 32'h0);
    chk("same_edge_lo", lo_reg, 32'd35);
    start = 1'b1; op = OP_MULTU; rs_val = 32'h0000ABCD; rt_val = 32'd1; mthi = 1'b1;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    chk("same_edge_mthi_visible", hi_reg, 32'h0000ABCD);
    repeat (40) @(negedge clk);
    chk("same_edge2_hi", hi_reg, 32'h0);
    chk("same_edge2_lo", lo_reg, 32'h0000ABCD);

    // Reset in the middle of a MULTU 2x3
    start = 1'b1; op = OP_MULTU; rs_val = 32'd2; rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midreset_hi", hi_reg, 32'h0);
    chk("midreset_lo", lo_reg, 32'h0);
    chk("midreset_busy", 32'(busy), 32'h0);
    chk("midreset_done", 32'(done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", 32'(busy), 32'h0);

    do_op(OP_MULTU, 32'd4, 32'd4, 1'b0, 1'b0, bc, dc, both, dzf);
    chk("after_reset_busy_cycles", 32'(bc), 32'd33);
    chk("after_reset_done_pulses", 32'(dc), 32'd1);
    chk("after_reset_hi", hi_reg, 32'h0);
    chk("after_reset_lo", lo_reg, 32'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
